// File: rtl/classifier_helpers_frequency_to_bin_if.sv
// Request/result bundle for classifier_helpers_frequency_to_bin.
//   master : drives the request (recv_val/recv_freq/recv_fs) and accepts the result (send_rdy)
//   slave  : the converter itself; returns recv_rdy and the result (send_val/send_bin/send_sat)
interface classifier_helpers_frequency_to_bin_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 16
);
  localparam int LOG2_N_SAMPLES = $clog2(N_SAMPLES);

  logic                      recv_val;
  logic                      recv_rdy;
  logic [BIT_WIDTH-1:0]      recv_freq;
  logic [BIT_WIDTH-1:0]      recv_fs;
  logic                      send_val;
  logic                      send_rdy;
  logic [LOG2_N_SAMPLES-1:0] send_bin;
  logic                      send_sat;

  modport master (
    output recv_val, recv_freq, recv_fs, send_rdy,
    input  recv_rdy, send_val, send_bin, send_sat
  );

  modport slave (
    input  recv_val, recv_freq, recv_fs, send_rdy,
    output recv_rdy, send_val, send_bin, send_sat
  );
endinterface

// File: rtl/classifier_helpers_frequency_to_bin.sv
// classifier_helpers_frequency_to_bin
// Maps a frequency to the FFT bin it falls in, for bins placed at
// bin_freq(b) = floor(b * fs / 2^(LOG2_N_SAMPLES+1)). A binary search resolves
// one index bit per cycle, from the MSB down.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): recv_val/recv_rdy/recv_freq/recv_fs request,
//                send_val/send_rdy/send_bin/send_sat result (sat = 2*freq >= fs)
// Build option: CLASSIFIER_FREQ_BIN_ROUND_EN adds a ROUND state after the search.
// This state rounds the result to the nearest bin. Ties round down.
//
// state  | meaning
// IDLE   | recv_rdy high, waiting for a request
// SEARCH | resolving one index bit per cycle, MSB first
// ROUND  | (ROUND_EN only) move to b+1 when it is strictly nearer
// DONE   | result presented, waiting for send_rdy
module classifier_helpers_frequency_to_bin #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 16
) (
  input logic                                 clk,
  input logic                                 reset,
  classifier_helpers_frequency_to_bin_if.slave bus
);
  localparam int LOG2_N_SAMPLES = $clog2(N_SAMPLES);
  localparam int PW             = LOG2_N_SAMPLES + BIT_WIDTH;

  if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)) begin : g_bad_n_samples
    $error("N_SAMPLES must be a power of 2 and >= 2");
  end

`ifdef CLASSIFIER_FREQ_BIN_ROUND_EN
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ROUND, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;
`endif

  // The product b*fs needs LOG2_N_SAMPLES+BIT_WIDTH bits. Extend it before the multiply, so it never wraps.
  function automatic logic [PW-1:0] bin_freq(input logic [LOG2_N_SAMPLES-1:0] b,
                                             input logic [BIT_WIDTH-1:0]      fs);
    logic [PW-1:0] prod;
    prod = PW'(b) * PW'(fs);
    return prod >> (LOG2_N_SAMPLES + 1);
  endfunction

  state_t                    state_q, state_d;
  logic [BIT_WIDTH-1:0]      freq_q, freq_d;
  logic [BIT_WIDTH-1:0]      fs_q, fs_d;
  logic [LOG2_N_SAMPLES-1:0] idx_q, idx_d;
  // Bit pointer stored one-hot. The last search step is the cycle where mask_q[0] is set.
  logic [LOG2_N_SAMPLES-1:0] mask_q, mask_d;
  logic                      recv_rdy_q, recv_rdy_d;
  logic                      send_val_q, send_val_d;
  logic [LOG2_N_SAMPLES-1:0] send_bin_q, send_bin_d;
  logic                      send_sat_q, send_sat_d;

  logic [LOG2_N_SAMPLES-1:0] trial;
  logic                      trial_ok;
  logic [BIT_WIDTH:0]        freq_x2;
  logic                      sat;

  assign trial    = idx_q | mask_q;
  assign trial_ok = bin_freq(trial, fs_q) <= PW'(freq_q);
  assign freq_x2  = {freq_q, 1'b0};
  assign sat      = freq_x2 >= {1'b0, fs_q};

`ifdef CLASSIFIER_FREQ_BIN_ROUND_EN
  logic [LOG2_N_SAMPLES-1:0] idx_inc;
  logic [PW-1:0]             bf_lo, bf_hi;
  logic                      round_up;

  // After the floor search, bf_lo <= freq < bf_hi holds whenever idx_q is not the top bin.
  // Both subtractions are therefore non-negative.
  assign idx_inc  = idx_q + LOG2_N_SAMPLES'(1);
  assign bf_lo    = bin_freq(idx_q, fs_q);
  assign bf_hi    = bin_freq(idx_inc, fs_q);
  assign round_up = (idx_q != {LOG2_N_SAMPLES{1'b1}}) &&
                    ((PW'(freq_q) - bf_lo) > (bf_hi - PW'(freq_q)));
`endif

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    fs_d       = fs_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    send_bin_d = send_bin_q;
    send_sat_d = send_sat_q;
    case (state_q)
      S_IDLE: begin
        if (bus.recv_val && recv_rdy_q) begin
          freq_d  = bus.recv_freq;
          fs_d    = bus.recv_fs;
          idx_d   = '0;
          mask_d  = LOG2_N_SAMPLES'(1) << (LOG2_N_SAMPLES - 1);
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (trial_ok) idx_d = trial;
        mask_d = mask_q >> 1;
        if (mask_q[0]) begin
`ifdef CLASSIFIER_FREQ_BIN_ROUND_EN
          state_d    = S_ROUND;
`else
          send_bin_d = trial_ok ? trial : idx_q;
          send_sat_d = sat;
          state_d    = S_DONE;
`endif
        end
      end
`ifdef CLASSIFIER_FREQ_BIN_ROUND_EN
      S_ROUND: begin
        send_bin_d = round_up ? idx_inc : idx_q;
        send_sat_d = sat;
        state_d    = S_DONE;
      end
`endif
      S_DONE: begin
        if (send_val_q && bus.send_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are registered from the next state, so they line up with the state flop.
    recv_rdy_d = (state_d == S_IDLE);
    send_val_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      freq_q     <= '0;
      fs_q       <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
      send_bin_q <= '0;
      send_sat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      fs_q       <= fs_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      recv_rdy_q <= recv_rdy_d;
      send_val_q <= send_val_d;
      send_bin_q <= send_bin_d;
      send_sat_q <= send_sat_d;
    end
  end

  assign bus.recv_rdy = recv_rdy_q;
  assign bus.send_val = send_val_q;
  assign bus.send_bin = send_bin_q;
  assign bus.send_sat = send_sat_q;
endmodule
